// File: rtl/cart_unlock_host.sv
// cart_unlock_host
//   Console-side initiator for the cartridge mapper unlock handshake.
//   Each attempt resets the cart, sends address 0x5A then 0xA5, and captures
//   the serial acknowledge frame from the mapper. A matching frame raises
//   UNLOCKED; otherwise the attempt is retried up to MAX_RETRY times before
//   FAIL is raised.
//
//   Ports:
//     CLK        system clock, shared with the mapper
//     RSTn       asynchronous active-low reset
//     START      unlock request, honoured only in IDLE, DONE or FAIL
//     SI         serial input from the mapper SO pin
//     ADDR       registered cart address byte
//     CART_RSTn  registered active-low cart reset
//     BUSY       high while a request is in progress
//     UNLOCKED   sticky, frame matched
//     FAIL       sticky, all attempts exhausted
//     RETRY_CNT  retries consumed in the current request
//     FRAME      last captured frame, bit 0 = first received
//
//   Build option:
//     SI_SYNC_EN  when defined, SI goes through a 2-flop synchronizer and two
//                 wait cycles are inserted ahead of RECV to cover its delay.
module cart_unlock_host #(
   parameter int unsigned          FRAME_LEN  = 18,
   parameter logic [FRAME_LEN-1:0] FRAME_PAT  = 18'h05140,
   parameter int unsigned          RST_CYCLES = 4,
   parameter int unsigned          MAX_RETRY  = 3,
   parameter logic [7:0]           IDLE_ADDR  = 8'h00
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 START,
   input  logic                 SI,
   output logic [7:0]           ADDR,
   output logic                 CART_RSTn,
   output logic                 BUSY,
   output logic                 UNLOCKED,
   output logic                 FAIL,
   output logic [1:0]           RETRY_CNT,
   output logic [FRAME_LEN-1:0] FRAME
);

   localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
   localparam int unsigned BCW = $clog2(FRAME_LEN);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CRST,
      ST_SEND_ACK,
      ST_SEND_NAK,
`ifdef SI_SYNC_EN
      ST_SYNC_WAIT,
`endif
      ST_RECV,
      ST_CHECK,
      ST_DONE,
      ST_FAIL
   } state_t;

   state_t           state;
   logic [RCW-1:0]   rst_cnt;
   logic [BCW-1:0]   bit_cnt;
   logic             si_smp;

`ifdef SI_SYNC_EN
   logic si_s1;
   logic si_s2;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         si_s1 <= 1'b0;
         si_s2 <= 1'b0;
      end else begin
         si_s1 <= SI;
         si_s2 <= si_s1;
      end
   end

   assign si_smp = si_s2;
`else
   assign si_smp = SI;
`endif

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= ST_IDLE;
         rst_cnt   <= '0;
         bit_cnt   <= '0;
         ADDR      <= IDLE_ADDR;
         CART_RSTn <= 1'b0;
         BUSY      <= 1'b0;
         UNLOCKED  <= 1'b0;
         FAIL      <= 1'b0;
         RETRY_CNT <= '0;
         FRAME     <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (START) begin
                  UNLOCKED  <= 1'b0;
                  FAIL      <= 1'b0;
                  RETRY_CNT <= '0;
                  bit_cnt   <= '0;
                  rst_cnt   <= '0;
                  CART_RSTn <= 1'b0;
                  ADDR      <= IDLE_ADDR;
                  BUSY      <= 1'b1;
                  state     <= ST_CRST;
               end
            end
            ST_CRST: begin
               if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
                  ADDR      <= 8'h5A;
                  CART_RSTn <= 1'b1;
                  state     <= ST_SEND_ACK;
               end else begin
                  rst_cnt <= rst_cnt + RCW'(1);
               end
            end
            ST_SEND_ACK: begin
               ADDR  <= 8'hA5;
               state <= ST_SEND_NAK;
            end
            ST_SEND_NAK: begin
               ADDR <= IDLE_ADDR;
`ifdef SI_SYNC_EN
               rst_cnt <= '0;
               state   <= ST_SYNC_WAIT;
`else
               state <= ST_RECV;
`endif
            end
`ifdef SI_SYNC_EN
            // rst_cnt is idle here, so it doubles as the 2-cycle wait counter
            ST_SYNC_WAIT: begin
               if (rst_cnt != '0) begin
                  state <= ST_RECV;
               end else begin
                  rst_cnt <= RCW'(1);
               end
            end
`endif
            // New bit enters at the MSB, so the first bit ends up in FRAME[0]
            ST_RECV: begin
               FRAME <= {si_smp, FRAME[FRAME_LEN-1:1]};
               if (bit_cnt == BCW'(FRAME_LEN - 1)) begin
                  state <= ST_CHECK;
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            ST_CHECK: begin
               if (FRAME == FRAME_PAT) begin
                  UNLOCKED <= 1'b1;
                  BUSY     <= 1'b0;
                  state    <= ST_DONE;
               end else if (RETRY_CNT < 2'(MAX_RETRY)) begin
                  RETRY_CNT <= RETRY_CNT + 2'd1;
                  CART_RSTn <= 1'b0;
                  rst_cnt   <= '0;
                  bit_cnt   <= '0;
                  state     <= ST_CRST;
               end else begin
                  FAIL      <= 1'b1;
                  BUSY      <= 1'b0;
                  CART_RSTn <= 1'b0;
                  state     <= ST_FAIL;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cart_unlock_host.sv
// tb_cart_unlock_host
//   Randomized and directed bench for cart_unlock_host. A behavioural mapper
//   answers each 0x5A/0xA5 address pair with the next queued frame (or the
//   correct pattern once the queue is empty). Expected outcomes are derived
//   from the number of wrong frames queued per request.
module tb_cart_unlock_host;

   localparam logic [17:0] PAT   = 18'h05140;
   localparam int          RSTC  = 4;
   localparam int          MAXR  = 3;
`ifdef SI_SYNC_EN
   localparam int          LAT   = RSTC + 23;
`else
   localparam int          LAT   = RSTC + 21;
`endif

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        START = 1'b0;
   logic        SI;
   logic [7:0]  ADDR;
   logic        CART_RSTn;
   logic        BUSY;
   logic        UNLOCKED;
   logic        FAIL;
   logic [1:0]  RETRY_CNT;
   logic [17:0] FRAME;

   int n_tests = 0;
   int n_fail  = 0;

   cart_unlock_host #(
      .FRAME_LEN (18),
      .FRAME_PAT (PAT),
      .RST_CYCLES(RSTC),
      .MAX_RETRY (MAXR),
      .IDLE_ADDR (8'h00)
   ) dut (
      .CLK      (CLK),
      .RSTn     (RSTn),
      .START    (START),
      .SI       (SI),
      .ADDR     (ADDR),
      .CART_RSTn(CART_RSTn),
      .BUSY     (BUSY),
      .UNLOCKED (UNLOCKED),
      .FAIL     (FAIL),
      .RETRY_CNT(RETRY_CNT),
      .FRAME    (FRAME)
   );

   always #5 CLK = ~CLK;

   // Mapper model: samples ADDR on each edge, loads a frame after 5A then A5
   logic [17:0] pat_q[$];
   logic [17:0] sh = '1;
   logic [7:0]  last_addr = 8'h00;

   always @(posedge CLK) begin
      last_addr <= ADDR;
      if (last_addr == 8'h5A && ADDR == 8'hA5 && CART_RSTn) begin
         if (pat_q.size() > 0) sh <= pat_q.pop_front();
         else                   sh <= PAT;
      end else begin
         sh <= {1'b1, sh[17:1]};
      end
   end

   assign SI = CART_RSTn ? sh[0] : 1'bx;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"},  32'(ADDR),      32'h00);
      check({tag, "_crst"},  32'(CART_RSTn), 32'd0);
      check({tag, "_busy"},  32'(BUSY),      32'd0);
      check({tag, "_unl"},   32'(UNLOCKED),  32'd0);
      check({tag, "_fail"},  32'(FAIL),      32'd0);
      check({tag, "_retry"}, 32'(RETRY_CNT), 32'd0);
      check({tag, "_frame"}, 32'(FRAME),     32'd0);
   endtask

   // k wrong frames are served before the correct one; ga/gb are cycles
   // after which a stray START pulse is driven (-1 for none).
   task automatic run_req(input int k, input bit ones, input int ga, input int gb);
      logic [17:0] w [0:7];
      int attempts, end_exp, cyc, n5a, na5, f5a, fa5, nlow, budget;
      bit ok, done;
      pat_q.delete();
      for (int i = 0; i < k; i++) begin
         w[i] = ones ? 18'h3FFFF : 18'($urandom);
         if (w[i] == PAT) w[i] = w[i] ^ 18'h00001;
         pat_q.push_back(w[i]);
      end
      ok       = (k <= MAXR);
      attempts = ok ? k + 1 : MAXR + 1;
      end_exp  = attempts * LAT;
      budget   = (MAXR + 1) * LAT + 20;

      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      cyc = 0; n5a = 0; na5 = 0; f5a = -1; fa5 = -1; nlow = 0; done = 0;
      check("busy_start", 32'(BUSY), 32'd1);
      check("unl_clear",  32'(UNLOCKED), 32'd0);
      check("retry_clear", 32'(RETRY_CNT), 32'd0);
      nlow = CART_RSTn ? 0 : 1;
      while (!done && cyc < budget) begin
         @(posedge CLK);
         #1;
         cyc++;
         if (ADDR == 8'h5A) begin n5a++; if (f5a < 0) f5a = cyc; end
         if (ADDR == 8'hA5) begin na5++; if (fa5 < 0) fa5 = cyc; end
         if (UNLOCKED || FAIL) done = 1;
         else if (!CART_RSTn) nlow++;
         START = (cyc == ga || cyc == gb);
      end
      START = 1'b0;
      check("end_cycle",  32'(cyc),       32'(end_exp));
      check("unlocked",   32'(UNLOCKED),  32'(ok));
      check("fail",       32'(FAIL),      32'(!ok));
      check("retry_cnt",  32'(RETRY_CNT), 32'(attempts - 1));
      check("frame",      32'(FRAME),     32'(ok ? PAT : w[MAXR]));
      check("busy_end",   32'(BUSY),      32'd0);
      check("cart_rstn",  32'(CART_RSTn), 32'(ok));
      check("addr_idle",  32'(ADDR),      32'h00);
      check("n_5a",       32'(n5a),       32'(attempts));
      check("n_a5",       32'(na5),       32'(attempts));
      check("first_5a",   32'(f5a),       32'(RSTC));
      check("first_a5",   32'(fa5),       32'(RSTC + 1));
      check("crst_low",   32'(nlow),      32'(attempts * RSTC));
   endtask

   initial begin
      #12;
      check_reset_vals("por");
      @(negedge CLK);
      RSTn = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("cart_held", 32'(CART_RSTn), 32'd0);

      run_req(0, 1'b0, -1, -1);
      run_req(1, 1'b0, -1, -1);
      run_req(4, 1'b1, -1, -1);
      run_req(0, 1'b0, 5, 12);

      // reset asserted mid-frame, then a clean request
      @(negedge CLK);
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (15) @(posedge CLK);
      #1;
      RSTn = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge CLK);
      RSTn = 1'b1;
      run_req(0, 1'b0, -1, -1);

      for (int r = 0; r < 6; r++) begin
         run_req($urandom_range(0, 5), 1'($urandom_range(0, 1)), -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
